inv_sub_bytes_iter: RTL
=======================

# inv_sub_bytes_iter

Iterative InvSubBytes engine for the AES-128 decryption datapath. It accepts a 128-bit state over a valid/ready handshake and replaces every byte with its inverse S-box value: the inverse affine transform first, then the GF(2^8) multiplicative inverse. It processes LANES bytes per cycle and returns the result on a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the inverse round, and complements the forward affine/S-box path used by encryption.

## Interface
- LANES, 4, bytes transformed per cycle; legal values 1, 2, 4, 8, 16.
- clk  input  1  rising-edge clock; the block uses this one clock only.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_state is valid.
- in_ready  output  1  block can accept a state.
- in_state  input  128  input state; byte i = in_state[127-8i -: 8].
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream accepts the result.
- out_state  output  128  transformed state, same byte order as in_state.
- busy  output  1  high in RUN (and FLUSH, see Configuration).

## Operation
- NBEATS = 16/LANES.
- The FSM has three states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready: load the state register with in_state, set beat=0, go to RUN.
  - RUN: on each edge, transform bytes beat*LANES .. beat*LANES+LANES-1 in place and increment beat. When beat==NBEATS-1, go to DONE.
  - DONE: out_valid=1 and out_state = state register. On out_ready, go to IDLE. Hold out_valid and out_state stable while out_ready=0.
- Per-byte function:
  - Inverse affine: y[i] = x[(i+2)%8] ^ x[(i+5)%8] ^ x[(i+7)%8] ^ c[i], with c=8'h05.
  - Then z = y^254 in GF(2^8) modulo x^8+x^4+x^3+x+1. The inverse of 0 is defined as 0.
- Bytes outside the current beat are unchanged. The beat counter is ceil(log2(NBEATS)) bits wide (minimum 1) and never wraps inside a block.
- in_ready is driven only from FSM state. There is no combinational path from in_valid or out_ready to any output.
- in_valid is ignored outside IDLE. in_state is sampled only on the accepting edge.

## Timing
- Reset values: in_ready=0 while rst is high, and 1 in the first cycle after rst drops. out_valid=0, busy=0, out_state=128'h0, FSM=IDLE, beat=0.
- Latency: acceptance at edge E0 → out_valid high after edge E(NBEATS). For LANES=4 that is 4 edges.
- Throughput: at most one block per NBEATS+2 cycles. The IDLE cycle after DONE is mandatory.
- Out handshake: transfer on the edge where out_valid && out_ready; out_valid is low on the next cycle.
- Reset mid-operation: rst in RUN or DONE discards the block. All outputs return to their reset values on that edge, and no partial result is ever presented.
- rst has priority over every handshake on the same edge.

## Configuration
- INV_SUB_BYTES_REG_EN
  - Defined: a register sits between the inverse affine stage and the GF inverse in each lane. Each beat then takes 2 edges, pipelined:
    - the affine result for beat b is registered while the GF inverse of beat b-1 is written back;
    - one extra FLUSH state follows RUN.
    - Latency is NBEATS+1 edges after acceptance.
  - Undefined: the lane is purely combinational and latency is NBEATS edges.
- Results are bit-identical with and without the macro.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_W=128 and AES_NBYTES=16;
  - INV_AFFINE_C=8'h05 and the reduction polynomial 9'h11B;
  - the FSM state enum (IDLE, RUN, DONE, FLUSH).
- One sub-module, inv_sbox: 8-bit combinational inverse affine followed by GF(2^8) inversion. It is instantiated LANES times. Under INV_SUB_BYTES_REG_EN it exposes its mid-point so the top can place the pipeline register.
- Top-level FSM, beat counter and state register: roughly 150–250 lines.

## Test plan
- All bytes 0x63 → all 0x00. All bytes 0x00 → all 0x52. out_valid rises exactly 4 edges after acceptance with LANES=4, or 5 edges with INV_SUB_BYTES_REG_EN.
- in_state=0x637C777BF26B6FC53001672BFED7AB76 → out_state=0x000102030405060708090A0B0C0D0E0F.
- Single-byte spot checks: 0x7C→0x01, 0xED→0x53, 0x64→0x8C, 0x16→0xFF. Placing each byte in position 0, 7 and 15 exercises every beat.
- Backpressure: out_ready=0 for 10 cycles after out_valid → out_valid=1 and out_state stable throughout, in_ready=0. A new in_valid during this window is not accepted.
- Reset after 2 beats of a block → next cycle out_valid=0, busy=0, out_state=0, in_ready=1. The following block (all 0x63) yields all 0x00.
- Exhaustive byte sweep, repeated for LANES ∈ {1, 16}: 16 blocks covering 0x00–0xFF, each compared against the inverse of a reference forward S-box.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, inverse-round FSM states and GF(2^8) helpers.
// The GF helpers are used by inv_sbox. They serve both builds, with and without INV_SUB_BYTES_REG_EN.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W  = 128;
    localparam int unsigned AES_NBYTES   = 16;
    localparam logic [7:0]  INV_AFFINE_C = 8'h05;
    localparam logic [8:0]  GF_POLY      = 9'h11B;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StFlush
    } isb_state_e;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
        end
        return acc;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Single-byte inverse S-box: the inverse affine transform, then the GF(2^8) inverse.
// When INV_SUB_BYTES_REG_EN is defined, the affine result leaves the module through aff_o.
// The inverse is then taken from mid_i, so the parent can register the mid-point.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] x_i,
`ifdef INV_SUB_BYTES_REG_EN
    output logic [7:0] aff_o,
    input  logic [7:0] mid_i,
`endif
    output logic [7:0] z_o
);

    logic [7:0] aff;

    always_comb begin
        aff = 8'h00;
        for (int i = 0; i < 8; i++) begin
            aff[i] = x_i[3'(i + 2)] ^ x_i[3'(i + 5)] ^ x_i[3'(i + 7)] ^ INV_AFFINE_C[i];
        end
    end

`ifdef INV_SUB_BYTES_REG_EN
    assign aff_o = aff;
    assign z_o   = gf_inv(mid_i);
`else
    assign z_o   = gf_inv(aff);
`endif

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: LANES bytes of the 128-bit state are transformed per beat.
// When INV_SUB_BYTES_REG_EN is defined, a per-lane mid-point register and a FLUSH state are added.
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_state,
    output logic                   busy
);

    localparam int unsigned NBEATS = AES_NBYTES / LANES;
    localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    isb_state_e                   state_q, state_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [AES_NBYTES-1:0][7:0]   data_q, data_d;
    logic [LANES-1:0][7:0]        lane_x, lane_z;

    // Byte i of the state lives at data_q[15-i], matching in_state[127-8i -: 8].
    function automatic logic [3:0] byte_idx(input logic [BEAT_W-1:0] b, input int l);
        return 4'(int'(AES_NBYTES) - 1 - (int'(b) * int'(LANES) + l));
    endfunction

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_x[l] = data_q[byte_idx(beat_q, l)];
        end
    end

`ifdef INV_SUB_BYTES_REG_EN
    logic [LANES-1:0][7:0] lane_aff;
    logic [LANES-1:0][7:0] mid_q, mid_d;
    logic [BEAT_W-1:0]     wb_beat_q, wb_beat_d;
    logic                  wb_valid_q, wb_valid_d;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef INV_SUB_BYTES_REG_EN
        inv_sbox u_inv_sbox (
            .x_i   (lane_x[l]),
            .aff_o (lane_aff[l]),
            .mid_i (mid_q[l]),
            .z_o   (lane_z[l])
        );
`else
        inv_sbox u_inv_sbox (
            .x_i (lane_x[l]),
            .z_o (lane_z[l])
        );
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (beat_q == LAST_BEAT) begin
`ifdef INV_SUB_BYTES_REG_EN
                    state_d = StFlush;
`else
                    state_d = StDone;
`endif
                end
            end
            StFlush: state_d = StDone;
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs; in_ready is held low while rst is asserted.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            StIdle:  in_ready  = !rst;
            StRun:   busy      = 1'b1;
            StFlush: busy      = 1'b1;
            StDone:  out_valid = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    assign out_state = (state_q == StDone) ? data_q : '0;

    // Datapath next state: load on accept, in-place write-back during RUN/FLUSH.
    always_comb begin
        beat_d = beat_q;
        data_d = data_q;
`ifdef INV_SUB_BYTES_REG_EN
        mid_d      = mid_q;
        wb_beat_d  = wb_beat_q;
        wb_valid_d = wb_valid_q;
`endif
        if (state_q == StIdle && in_valid) begin
            data_d = in_state;
            beat_d = '0;
`ifdef INV_SUB_BYTES_REG_EN
            wb_valid_d = 1'b0;
`endif
        end else if (state_q == StRun) begin
            if (beat_q != LAST_BEAT) begin
                beat_d = beat_q + 1'b1;
            end
`ifdef INV_SUB_BYTES_REG_EN
            mid_d      = lane_aff;
            wb_beat_d  = beat_q;
            wb_valid_d = 1'b1;
            if (wb_valid_q) begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[byte_idx(wb_beat_q, l)] = lane_z[l];
                end
            end
`else
            for (int l = 0; l < LANES; l++) begin
                data_d[byte_idx(beat_q, l)] = lane_z[l];
            end
`endif
        end else if (state_q == StFlush) begin
`ifdef INV_SUB_BYTES_REG_EN
            if (wb_valid_q) begin
                for (int l = 0; l < LANES; l++) begin
                    data_d[byte_idx(wb_beat_q, l)] = lane_z[l];
                end
            end
            wb_valid_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q     <= '0;
            data_q     <= '0;
`ifdef INV_SUB_BYTES_REG_EN
            mid_q      <= '0;
            wb_beat_q  <= '0;
            wb_valid_q <= 1'b0;
`endif
        end else begin
            beat_q     <= beat_d;
            data_q     <= data_d;
`ifdef INV_SUB_BYTES_REG_EN
            mid_q      <= mid_d;
            wb_beat_q  <= wb_beat_d;
            wb_valid_q <= wb_valid_d;
`endif
        end
    end

endmodule
